weight_multibank_buffer: RTL and testbench
==========================================

WEIGHT_MULTIBANK_BUFFER -- requirements
Module: weight_multibank_buffer

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 3, weight banks in the ring (legal 2..8, non-power-of-2 allowed).
REQ-002 SHALL have parameter ARRAY_DIM, default 8, rows per bank and row elements (legal 2..64).
REQ-003 SHALL have parameter DATA_WIDTH, default 8, bits per weight element.
REQ-004 SHALL have ports: clk  in  1  sole clock; rising edge.
REQ-005 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: wr_valid  in  1, wr_ready  out  1, wr_row  in  clog2(ARRAY_DIM), wr_data  in  ARRAY_DIM*DATA_WIDTH; row write handshake.
REQ-007 SHALL have ports: swap_req  in  1  request to activate oldest full bank; swap_ack  out  1  one-cycle acceptance pulse.
REQ-008 SHALL have ports: load_valid  out  1, load_row  out  clog2(ARRAY_DIM), load_data  out  ARRAY_DIM*DATA_WIDTH, load_last  out  1; row stream to PE array.
REQ-009 SHALL have ports: rd_row  in  clog2(ARRAY_DIM), rd_data  out  ARRAY_DIM*DATA_WIDTH; random read of active bank.
REQ-010 SHALL have ports: flush  in  1; err_clr  in  1; err_underflow  out  1; active_valid  out  1; banks_full  out  clog2(NUM_BANKS+1); streaming  out  1.

Function
REQ-011 Bank roles: one FILLING bank at fill_ptr, FIFO of FULL banks from head_ptr (count banks_full), at most one ACTIVE bank at act_ptr; pointers wrap NUM_BANKS-1 -> 0.
REQ-012 wr_ready = (banks_full + active_valid) < NUM_BANKS and not flush; write accepted iff wr_valid && wr_ready.
REQ-013 Accepted write stores wr_data into fill bank row wr_row and sets that row's bit in a per-bank row mask; rewriting a row overwrites data, sets no extra bit.
REQ-014 Cycle after the mask becomes all-ones: banks_full +1, fill_ptr advances, new fill bank mask cleared; wr_ready may deassert that cycle.
REQ-015 FSM states IDLE, STREAM; reset state IDLE.
REQ-016 IDLE, swap_req, banks_full>0: accept; act_ptr<=head_ptr, head_ptr advances, banks_full -1, previous active bank freed, active_valid<=1, swap_ack=1 next cycle, go STREAM.
REQ-017 IDLE, swap_req, banks_full==0: no state change, err_underflow set (sticky) next cycle.
REQ-018 STREAM: swap_req ignored, no error; load_valid=1 for exactly ARRAY_DIM consecutive cycles, load_row 0..ARRAY_DIM-1, load_data = active bank row; first row coincides with swap_ack; load_last with final row; then IDLE.
REQ-019 Commit (REQ-014) and swap accept same cycle: swap uses pre-commit banks_full; net banks_full unchanged.
REQ-020 rd_data registered, 1-cycle latency from rd_row; zero when active_valid=0.
REQ-021 flush (sync, 1 cycle): all masks cleared, banks_full=0, active_valid=0, pointers to 0, STREAM aborted to IDLE with load_valid=0 next cycle; bank data not cleared; err_underflow kept.
REQ-022 err_clr clears err_underflow; simultaneous underflow event wins (flag stays set).
REQ-023 streaming = (state==STREAM); swap_ack, load_last single-cycle pulses.

Reset
REQ-024 During rst: wr_ready=0, swap_ack=0, load_valid=0, load_row=0, load_data=0, load_last=0, rd_data=0, err_underflow=0, active_valid=0, banks_full=0, streaming=0.
REQ-025 Reset clears pointers and all row masks; bank data storage need not be reset.
REQ-026 Reset mid-STREAM or mid-fill aborts immediately; first cycle after deassert wr_ready=1.

Structure
REQ-027 State enum (IDLE, STREAM) and NUM_BANKS legal-range constants SHALL live in rftpu_pkg.
REQ-028 One sub-module weight_bank: ARRAY_DIM-row storage, row mask, all_loaded and clear inputs; instantiated NUM_BANKS times.
REQ-029 Elaboration SHALL fail for NUM_BANKS outside 2..8.

Verification
REQ-030 Defaults; write rows 0..7 to bank0, swap_req -> swap_ack 1 cycle later, load_row 0..7 over 8 cycles, load_last on row 7, banks_full 1->0.
REQ-031 Write row 3 twice (0x11.., 0x22..) then rows 0..7 minus 3 -> bank commits after 8 distinct rows; streamed row 3 = 0x22...
REQ-032 Fill 3 banks' worth without swap -> wr_ready=0 after 3rd commit; swap frees nothing until 2nd swap, then wr_ready=1.
REQ-033 swap_req with banks_full=0 -> no swap_ack, err_underflow=1; err_clr -> 0.
REQ-034 NUM_BANKS=3, 7 fill/swap rounds -> act_ptr sequence 0,1,2,0,1,2,0 and data matches per round.
REQ-035 flush at 3rd stream row -> load_valid=0 next cycle, banks_full=0, active_valid=0; rst mid-fill -> all outputs per REQ-024.

Source files
------------

// File: rtl/rftpu_pkg.sv
// Shared types and constants for the weight buffer: stream FSM states,
// legal bank-count range and ring-pointer arithmetic.
package rftpu_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } buf_state_t;

    localparam int NUM_BANKS_MIN = 2;
    localparam int NUM_BANKS_MAX = 8;

    // Ring increment that also works for non-power-of-2 bank counts.
    function automatic int wrap_inc(input int ptr, input int n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/weight_bank.sv
// One weight bank: ARRAY_DIM rows of storage, a per-row loaded mask and
// two combinational row read ports (stream and random read).
module weight_bank #(
    parameter int ARRAY_DIM  = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            wr_en,
    input  logic [$clog2(ARRAY_DIM)-1:0]    wr_row,
    input  logic [ARRAY_DIM*DATA_WIDTH-1:0] wr_data,
    input  logic [$clog2(ARRAY_DIM)-1:0]    load_row,
    output logic [ARRAY_DIM*DATA_WIDTH-1:0] load_data,
    input  logic [$clog2(ARRAY_DIM)-1:0]    rd_row,
    output logic [ARRAY_DIM*DATA_WIDTH-1:0] rd_data,
    output logic                            all_loaded
);

    localparam int LINE_W = ARRAY_DIM * DATA_WIDTH;

    logic [LINE_W-1:0]    mem [ARRAY_DIM];
    logic [ARRAY_DIM-1:0] row_mask;

    // NOTE: row storage has no reset so it maps onto plain RAM; only the
    // mask needs a known value, and it carries all the bank's state.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_row] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_mask <= '0;
        end else if (clear) begin
            row_mask <= '0;
        end else if (wr_en) begin
            row_mask[wr_row] <= 1'b1;
        end
    end

    assign all_loaded = &row_mask;
    assign load_data  = mem[load_row];
    assign rd_data    = mem[rd_row];

endmodule

// File: rtl/weight_multibank_buffer.sv
// Ring of weight banks: one filling, a FIFO of full banks and one active
// bank that is streamed row by row to the PE array on swap.
module weight_multibank_buffer
    import rftpu_pkg::*;
#(
    parameter int NUM_BANKS  = 3,
    parameter int ARRAY_DIM  = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [$clog2(ARRAY_DIM)-1:0]      wr_row,
    input  logic [ARRAY_DIM*DATA_WIDTH-1:0]   wr_data,
    input  logic                              swap_req,
    output logic                              swap_ack,
    output logic                              load_valid,
    output logic [$clog2(ARRAY_DIM)-1:0]      load_row,
    output logic [ARRAY_DIM*DATA_WIDTH-1:0]   load_data,
    output logic                              load_last,
    input  logic [$clog2(ARRAY_DIM)-1:0]      rd_row,
    output logic [ARRAY_DIM*DATA_WIDTH-1:0]   rd_data,
    input  logic                              flush,
    input  logic                              err_clr,
    output logic                              err_underflow,
    output logic                              active_valid,
    output logic [$clog2(NUM_BANKS+1)-1:0]    banks_full,
    output logic                              streaming
);

    localparam int ROW_W  = $clog2(ARRAY_DIM);
    localparam int PTR_W  = $clog2(NUM_BANKS);
    localparam int CNT_W  = $clog2(NUM_BANKS + 1);
    localparam int LINE_W = ARRAY_DIM * DATA_WIDTH;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ARRAY_DIM - 1);

    if (NUM_BANKS < NUM_BANKS_MIN || NUM_BANKS > NUM_BANKS_MAX) begin : g_bad_num_banks
        $error("weight_multibank_buffer: NUM_BANKS must be within 2..8");
    end

    buf_state_t        state_q, state_d;
    logic [ROW_W-1:0]  row_cnt;
    logic [PTR_W-1:0]  fill_ptr, head_ptr, act_ptr, fill_next, head_next;

    logic [LINE_W-1:0] bank_load_data [NUM_BANKS];
    logic [LINE_W-1:0] bank_rd_data   [NUM_BANKS];
    logic [NUM_BANKS-1:0] bank_all_loaded, bank_wr_en, bank_clear;

    logic fill_full, commit, wr_accept, swap_accept, underflow_evt;

    assign fill_next = PTR_W'(wrap_inc(int'(fill_ptr), NUM_BANKS));
    assign head_next = PTR_W'(wrap_inc(int'(head_ptr), NUM_BANKS));

    // A fill bank that just completed is committed this cycle; block writes
    // so the committed rows cannot be overwritten.
    assign fill_full     = bank_all_loaded[fill_ptr];
    assign commit        = fill_full && !flush;
    assign wr_ready      = !rst && !flush && !fill_full &&
                           ((int'(banks_full) + int'(active_valid)) < NUM_BANKS);
    assign wr_accept     = wr_valid && wr_ready;
    assign swap_accept   = (state_q == IDLE) && swap_req && !flush && (banks_full != '0);
    assign underflow_evt = (state_q == IDLE) && swap_req && !flush && (banks_full == '0);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign bank_wr_en[b] = wr_accept && (fill_ptr == PTR_W'(b));
        assign bank_clear[b] = flush || (commit && (fill_next == PTR_W'(b)));

        weight_bank #(
            .ARRAY_DIM (ARRAY_DIM),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .clear     (bank_clear[b]),
            .wr_en     (bank_wr_en[b]),
            .wr_row    (wr_row),
            .wr_data   (wr_data),
            .load_row  (row_cnt),
            .load_data (bank_load_data[b]),
            .rd_row    (rd_row),
            .rd_data   (bank_rd_data[b]),
            .all_loaded(bank_all_loaded[b])
        );
    end

    // Ring bookkeeping; a commit and a swap in one cycle cancel in banks_full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_ptr     <= '0;
            head_ptr     <= '0;
            act_ptr      <= '0;
            banks_full   <= '0;
            active_valid <= 1'b0;
        end else if (flush) begin
            fill_ptr     <= '0;
            head_ptr     <= '0;
            act_ptr      <= '0;
            banks_full   <= '0;
            active_valid <= 1'b0;
        end else begin
            if (commit) begin
                fill_ptr <= fill_next;
            end
            if (swap_accept) begin
                act_ptr      <= head_ptr;
                head_ptr     <= head_next;
                active_valid <= 1'b1;
            end
            case ({commit, swap_accept})
                2'b10:   banks_full <= banks_full + CNT_W'(1);
                2'b01:   banks_full <= banks_full - CNT_W'(1);
                default: banks_full <= banks_full;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_underflow <= 1'b0;
            rd_data       <= '0;
        end else begin
            if (underflow_evt) begin
                err_underflow <= 1'b1;
            end else if (err_clr) begin
                err_underflow <= 1'b0;
            end
            rd_data <= active_valid ? bank_rd_data[act_ptr] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_cnt <= '0;
        end else begin
            state_q <= state_d;
            row_cnt <= (state_q == STREAM && state_d == STREAM) ? row_cnt + ROW_W'(1) : '0;
        end
    end

    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (swap_accept) state_d = STREAM;
                STREAM:  if (row_cnt == LAST_ROW) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        streaming  = (state_q == STREAM);
        load_valid = streaming;
        load_row   = streaming ? row_cnt : '0;
        load_data  = streaming ? bank_load_data[act_ptr] : '0;
        load_last  = streaming && (row_cnt == LAST_ROW);
        swap_ack   = streaming && (row_cnt == '0);
    end

endmodule

// File: tb/tb_weight_multibank_buffer.sv
// Self-checking bench: directed scenarios plus random traffic, all outputs
// compared every cycle against a bank-ring model built from queues.
module tb_weight_multibank_buffer;

    localparam int NB = 3;
    localparam int AD = 8;
    localparam int DW = 8;
    localparam int LW = AD * DW;
    localparam int RW = $clog2(AD);
    localparam int CW = $clog2(NB + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0, wr_ready;
    logic [RW-1:0] wr_row = '0;
    logic [LW-1:0] wr_data = '0;
    logic          swap_req = 1'b0, swap_ack;
    logic          load_valid, load_last;
    logic [RW-1:0] load_row;
    logic [LW-1:0] load_data;
    logic [RW-1:0] rd_row = '0;
    logic [LW-1:0] rd_data;
    logic          flush = 1'b0, err_clr = 1'b0, err_underflow, active_valid, streaming;
    logic [CW-1:0] banks_full;

    always #5 clk = ~clk;

    weight_multibank_buffer #(
        .NUM_BANKS (NB),
        .ARRAY_DIM (AD),
        .DATA_WIDTH(DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_row       (wr_row),
        .wr_data      (wr_data),
        .swap_req     (swap_req),
        .swap_ack     (swap_ack),
        .load_valid   (load_valid),
        .load_row     (load_row),
        .load_data    (load_data),
        .load_last    (load_last),
        .rd_row       (rd_row),
        .rd_data      (rd_data),
        .flush        (flush),
        .err_clr      (err_clr),
        .err_underflow(err_underflow),
        .active_valid (active_valid),
        .banks_full   (banks_full),
        .streaming    (streaming)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: bank contents, queue of full banks, active bank,
    // rows loaded into the fill bank and the current stream row (-1 = none).
    bit [LW-1:0] m_mem [NB][AD];
    int          full_q[$];
    int          m_fill, m_act, m_srow;
    bit          m_act_v, m_err;
    bit [AD-1:0] m_loaded;
    bit [LW-1:0] m_rd;
    logic [LW-1:0] cap3;
    bit          dut_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        full_q.delete();
        m_fill   = 0;
        m_act    = 0;
        m_act_v  = 0;
        m_srow   = -1;
        m_loaded = '0;
        m_err    = 0;
        m_rd     = '0;
    endtask

    function automatic bit exp_ready();
        return !flush && !(&m_loaded) && ((full_q.size() + int'(m_act_v)) < NB);
    endfunction

    task automatic check_outputs();
        bit          s;
        bit [LW-1:0] ld;
        s  = (m_srow >= 0);
        ld = '0;
        if (s) ld = m_mem[m_act][m_srow];
        check("wr_ready",      wr_ready,      exp_ready());
        check("swap_ack",      swap_ack,      s && m_srow == 0);
        check("load_valid",    load_valid,    s);
        check("load_row",      load_row,      s ? m_srow : 0);
        check("load_data",     load_data,     ld);
        check("load_last",     load_last,     s && m_srow == AD - 1);
        check("rd_data",       rd_data,       m_rd);
        check("err_underflow", err_underflow, m_err);
        check("active_valid",  active_valid,  m_act_v);
        check("banks_full",    banks_full,    full_q.size());
        check("streaming",     streaming,     s);
    endtask

    task automatic check_reset_outputs();
        check("rst_wr_ready",   wr_ready,      0);
        check("rst_swap_ack",   swap_ack,      0);
        check("rst_load_valid", load_valid,    0);
        check("rst_load_row",   load_row,      0);
        check("rst_load_data",  load_data,     0);
        check("rst_load_last",  load_last,     0);
        check("rst_rd_data",    rd_data,       0);
        check("rst_err",        err_underflow, 0);
        check("rst_active",     active_valid,  0);
        check("rst_banks_full", banks_full,    0);
        check("rst_streaming",  streaming,     0);
    endtask

    // Advance the model by one clock using the inputs of the current cycle.
    task automatic model_step();
        bit pend, acc, sw, uf;
        pend = &m_loaded;
        acc  = wr_valid && exp_ready();
        m_rd = m_act_v ? m_mem[m_act][rd_row] : '0;
        if (flush) begin
            full_q.delete();
            m_fill   = 0;
            m_act    = 0;
            m_act_v  = 0;
            m_srow   = -1;
            m_loaded = '0;
            if (err_clr) m_err = 0;
            return;
        end
        if (acc) begin
            m_mem[m_fill][wr_row] = wr_data;
            m_loaded[wr_row]      = 1'b1;
        end
        sw = swap_req && m_srow < 0 && full_q.size() > 0;
        uf = swap_req && m_srow < 0 && full_q.size() == 0;
        if (m_srow >= 0) m_srow = (m_srow == AD - 1) ? -1 : m_srow + 1;
        if (sw) begin
            m_act   = full_q.pop_front();
            m_act_v = 1;
            m_srow  = 0;
        end
        if (pend) begin
            full_q.push_back(m_fill);
            m_fill   = (m_fill + 1) % NB;
            m_loaded = '0;
        end
        if (uf)           m_err = 1;
        else if (err_clr) m_err = 0;
    endtask

    // One clock: compare at the falling edge, step the model, return 1 after rise.
    task automatic cycle();
        rd_row = RW'($urandom_range(0, AD - 1));
        @(negedge clk);
        if (rst) begin
            check_reset_outputs();
            model_reset();
        end else begin
            check_outputs();
            dut_acc = wr_valid && wr_ready;
            if (load_valid && load_row == RW'(3)) cap3 = load_data;
            model_step();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input int r, input logic [LW-1:0] d);
        wr_valid = 1'b1;
        wr_row   = RW'(r);
        wr_data  = d;
        dut_acc  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            cycle();
            if (dut_acc) break;
        end
        check("wr_accept", dut_acc, 1);
        wr_valid = 1'b0;
    endtask

    task automatic fill_bank();
        for (int r = 0; r < AD; r++) write_row(r, {$urandom(), $urandom()});
        cycle();
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        cycle();
        swap_req = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    initial begin
        model_reset();
        cap3 = '0;
        repeat (2) cycle();
        rst = 1'b0;
        #1;
        check("wr_ready_after_rst", wr_ready, 1);

        // Basic fill, swap and stream of one bank.
        fill_bank();
        check("commit_banks_full", banks_full, 1);
        do_swap();
        check("swap_ack_first_row", swap_ack, 1);
        check("first_load_row", load_row, 0);
        check("banks_full_after_swap", banks_full, 0);
        repeat (AD) cycle();
        check("stream_done", load_valid, 0);

        // Row rewrite: last write wins and the bank needs AD distinct rows.
        write_row(3, {AD{8'h11}});
        write_row(3, {AD{8'h22}});
        for (int r = 0; r < AD; r++) if (r != 3) write_row(r, {$urandom(), $urandom()});
        cycle();
        check("rewrite_commit", banks_full, 1);
        cap3 = '0;
        do_swap();
        repeat (AD) cycle();
        check("row3_overwrite", cap3, {AD{8'h22}});

        // Ring full: the first swap frees nothing, the second frees a bank.
        do_flush();
        repeat (NB) fill_bank();
        check("ring_full_bf", banks_full, NB);
        check("ring_full_wr_ready", wr_ready, 0);
        do_swap();
        repeat (AD) cycle();
        check("swap1_no_free", wr_ready, 0);
        do_swap();
        check("swap2_frees", wr_ready, 1);
        repeat (AD) cycle();
        do_swap();
        repeat (AD) cycle();

        // Underflow and its sticky flag.
        do_swap();
        check("underflow_no_ack", swap_ack, 0);
        check("underflow_set", err_underflow, 1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        check("underflow_cleared", err_underflow, 0);

        // Seven rounds rotate the active bank around the ring.
        do_flush();
        for (int r = 0; r < 7; r++) begin
            fill_bank();
            do_swap();
            check("act_ptr_round", 64'(dut.act_ptr), 64'(r % NB));
            repeat (AD) cycle();
        end

        // Flush on the third streamed row, then reset mid-fill.
        do_flush();
        fill_bank();
        fill_bank();
        do_swap();
        cycle();
        cycle();
        check("third_row", load_row, 2);
        do_flush();
        check("flush_load_valid", load_valid, 0);
        check("flush_banks_full", banks_full, 0);
        check("flush_active", active_valid, 0);
        for (int r = 0; r < 3; r++) write_row(r, {$urandom(), $urandom()});
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        #1;
        check("wr_ready_after_rst_mid_fill", wr_ready, 1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            wr_valid = ($urandom() % 4) != 0;
            wr_row   = RW'($urandom_range(0, AD - 1));
            wr_data  = {$urandom(), $urandom()};
            swap_req = ($urandom() % 6) == 0;
            flush    = ($urandom() % 250) == 0;
            err_clr  = ($urandom() % 20) == 0;
            cycle();
        end
        wr_valid = 1'b0;
        swap_req = 1'b0;
        flush    = 1'b0;
        err_clr  = 1'b0;
        repeat (AD + 2) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
